load_store_unit: RTL and testbench

Memory-stage initiator that drives the 256×32 word-addressed data memory on behalf of the pipeline. Accepts one load/store request at a time from the MEM stage and decodes RV32I byte/halfword/word width and signedness. Performs read-modify-write for sub-word stores, sign/zero-extends loads, and flags misaligned or out-of-range accesses. It holds the pipeline via `stall` while a transaction is in flight.

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage: drives a 256x32 word memory,
// with sub-word read-modify-write, load extension and access checks.
module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        stall,
   output logic [7:0]  mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      RESP
   } state_t;

   state_t      state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [7:0]  word_q;
   logic [31:0] wdata_q;
   logic [31:0] wword_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        legal_ld;
   logic        legal_st;
   logic        acc_err;
   logic        accept;
   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] ld_ext;
   logic [31:0] merged;

   assign req_ready   = rst_n && (state == IDLE);
   assign accept      = req_valid && req_ready;
   assign stall       = (state != IDLE);
   assign resp_valid  = (state == RESP);
   assign resp_rdata  = rdata_q;
   assign resp_err    = err_q;
   assign mem_address = word_q;
   assign mem_wdata   = wword_q;
   assign mem_read    = rst_n && (state == RD);
   assign mem_write   = rst_n && (state == WR);

   always_comb begin
      legal_ld = 1'b0;
      legal_st = 1'b0;
      unique case (req_funct3)
         3'b000, 3'b001, 3'b010: begin
            legal_ld = 1'b1;
            legal_st = 1'b1;
         end
         3'b100, 3'b101: legal_ld = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      acc_err = req_we ? !legal_st : !legal_ld;
      if (|req_addr[31:10])
         acc_err = 1'b1;
      if (req_funct3[1:0] == 2'b01 && req_addr[0])
         acc_err = 1'b1;
      if (req_funct3[1:0] == 2'b10 && |req_addr[1:0])
         acc_err = 1'b1;
   end

   assign shamt   = {lane_q, 3'b000};
   assign shifted = mem_rdata >> shamt;

   always_comb begin
      ld_ext = mem_rdata;
      unique case (f3_q)
         3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ld_ext = {24'h0, shifted[7:0]};
         3'b101:  ld_ext = {16'h0, shifted[15:0]};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Replace only the addressed lanes of the word just read.
   always_comb begin
      if (f3_q[1:0] == 2'b00)
         merged = (mem_rdata & ~(32'h0000_00ff << shamt))
                | ({24'h0, wdata_q[7:0]} << shamt);
      else
         merged = (mem_rdata & ~(32'h0000_ffff << shamt))
                | ({16'h0, wdata_q[15:0]} << shamt);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         lane_q  <= 2'b00;
         word_q  <= 8'h00;
         wdata_q <= 32'h0;
         wword_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  lane_q  <= req_addr[1:0];
                  word_q  <= req_addr[9:2];
                  wdata_q <= req_wdata;
                  if (acc_err) begin
                     err_q <= 1'b1;
                     state <= RESP;
                  end else if (!req_we) begin
                     state <= RD;
                  end else if (req_funct3[1:0] == 2'b10) begin
                     wword_q <= req_wdata;
                     state   <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               if (we_q) begin
                  wword_q <= merged;
                  state   <= WR;
               end else begin
                  rdata_q <= ld_ext;
                  state   <= RESP;
               end
            end
            WR: state <= RESP;
            RESP: begin
               rdata_q <= 32'h0;
               err_q   <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors, random
// requests against a reference model, back-to-back and reset abort.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stall;
   logic [7:0]  mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   load_store_unit dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_funct3(req_funct3),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .stall(stall),
      .mem_address(mem_address),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [256];
   logic [31:0] init_mem [256];
   logic [31:0] ref_mem [256];
   logic        preload = 1'b0;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++)
            mem[i] <= init_mem[i];
      end else if (mem_write) begin
         mem[mem_address] <= mem_wdata;
      end
   end

   assign mem_rdata = mem[mem_address];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: what an access should do, from the RV32I rules.
   task automatic model(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata,
                        output int cyc, output int nrd, output int nwr);
      int w, lane, size;
      logic [31:0] word, v;
      w     = int'(addr[9:2]);
      lane  = int'(addr[1:0]);
      word  = ref_mem[w];
      rdata = 32'h0;
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (we)
         err = (f3 > 3'd2);
      else
         err = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      if (addr > 32'h3ff)
         err = 1'b1;
      if (addr % size != 0)
         err = 1'b1;
      if (err) begin
         cyc = 1; nrd = 0; nwr = 0;
         return;
      end
      if (!we) begin
         v = word >> (8 * lane);
         if (size == 1) v = v & 32'hff;
         if (size == 2) v = v & 32'hffff;
         if (!f3[2] && size == 1 && v[7]) v = v | 32'hffffff00;
         if (!f3[2] && size == 2 && v[15]) v = v | 32'hffff0000;
         rdata = v;
         cyc = 2; nrd = 1; nwr = 0;
      end else if (size == 4) begin
         ref_mem[w] = wdata;
         cyc = 2; nrd = 0; nwr = 1;
      end else begin
         for (int b = 0; b < size; b++)
            word[8*(lane+b) +: 8] = wdata[8*b +: 8];
         ref_mem[w] = word;
         cyc = 3; nrd = 1; nwr = 1;
      end
   endtask

   task automatic idle_check();
      @(negedge clk);
      req_valid = 1'b0;
      chk("idle_resp_valid", resp_valid, 0);
      chk("idle_resp_rdata", resp_rdata, 0);
      chk("idle_resp_err", resp_err, 0);
      chk("idle_stall", stall, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_strobes", {mem_read, mem_write}, 0);
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hold,
                         output logic err, output logic [31:0] rdata,
                         output int cyc, output int nrd, output int nwr);
      bit got;
      idle_check();
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      got = 0; cyc = 0; nrd = 0; nwr = 0; err = 0; rdata = 0;
      for (int k = 1; k <= 8 && !got; k++) begin
         @(negedge clk);
         chk("busy_stall", stall, 1);
         chk("busy_ready", req_ready, 0);
         chk("rd_wr_excl", mem_read && mem_write, 0);
         if (mem_read) nrd++;
         if (mem_write) nwr++;
         if (mem_read || mem_write)
            chk("mem_address", mem_address, addr[9:2]);
         if (resp_valid) begin
            got = 1; cyc = k; err = resp_err; rdata = resp_rdata;
         end
         req_we     = 1'($urandom);
         req_funct3 = 3'($urandom);
         req_addr   = $urandom;
         req_wdata  = $urandom;
         req_valid  = hold ? 1'b1 : 1'($urandom);
      end
      if (!got) chk("resp_timeout", 0, 1);
   endtask

   task automatic exec(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit hold, input bit has_exp,
                       input logic e_err, input logic [31:0] e_rd,
                       input int e_cyc);
      logic m_err, d_err;
      logic [31:0] m_rd, d_rd;
      int m_cyc, m_nrd, m_nwr, d_cyc, d_nrd, d_nwr;
      model(we, f3, addr, wdata, m_err, m_rd, m_cyc, m_nrd, m_nwr);
      if (!has_exp) begin
         e_err = m_err; e_rd = m_rd; e_cyc = m_cyc;
      end
      do_req(we, f3, addr, wdata, hold, d_err, d_rd, d_cyc, d_nrd, d_nwr);
      chk("resp_err", d_err, e_err);
      chk("resp_rdata", d_rd, e_rd);
      chk("latency", d_cyc, e_cyc);
      chk("read_cycles", d_nrd, m_nrd);
      chk("write_cycles", d_nwr, m_nwr);
      chk("mem_word", mem[addr[9:2]], ref_mem[addr[9:2]]);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } vec_t;

   vec_t vt [16];
   int   bad;

   initial begin
      vt[0]  = '{1'b0, 3'd0, 32'h015, 32'h0, 1'b0, 32'hffffffaa, 2};
      vt[1]  = '{1'b0, 3'd4, 32'h015, 32'h0, 1'b0, 32'h000000aa, 2};
      vt[2]  = '{1'b0, 3'd1, 32'h016, 32'h0, 1'b0, 32'hffff8899, 2};
      vt[3]  = '{1'b1, 3'd1, 32'h016, 32'hcafe1234, 1'b0, 32'h0, 3};
      vt[4]  = '{1'b0, 3'd2, 32'h014, 32'h0, 1'b0, 32'h1234aabb, 2};
      vt[5]  = '{1'b1, 3'd2, 32'h3fc, 32'hdeadbeef, 1'b0, 32'h0, 2};
      vt[6]  = '{1'b1, 3'd2, 32'h00a, 32'h11111111, 1'b1, 32'h0, 1};
      vt[7]  = '{1'b0, 3'd2, 32'h400, 32'h0, 1'b1, 32'h0, 1};
      vt[8]  = '{1'b0, 3'd3, 32'h000, 32'h0, 1'b1, 32'h0, 1};
      vt[9]  = '{1'b0, 3'd5, 32'h016, 32'h0, 1'b0, 32'h00001234, 2};
      vt[10] = '{1'b0, 3'd2, 32'h3fc, 32'h0, 1'b0, 32'hdeadbeef, 2};
      vt[11] = '{1'b1, 3'd0, 32'h017, 32'h00000055, 1'b0, 32'h0, 3};
      vt[12] = '{1'b0, 3'd0, 32'h017, 32'h0, 1'b0, 32'h00000055, 2};
      vt[13] = '{1'b1, 3'd4, 32'h000, 32'h0, 1'b1, 32'h0, 1};
      vt[14] = '{1'b0, 3'd1, 32'h015, 32'h0, 1'b1, 32'h0, 1};
      vt[15] = '{1'b0, 3'd0, 32'h014, 32'h0, 1'b0, 32'hffffffbb, 2};

      for (int i = 0; i < 256; i++) begin
         init_mem[i] = $urandom;
      end
      init_mem[5] = 32'h8899aabb;
      for (int i = 0; i < 256; i++)
         ref_mem[i] = init_mem[i];

      preload = 1'b1;
      req_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 preload = 1'b0;
      @(negedge clk);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ready", req_ready, 0);
      req_valid = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++)
         exec(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, 1'b0, 1'b1,
              vt[i].err, vt[i].rdata, vt[i].cyc);

      for (int i = 0; i < 4; i++)
         exec(1'b0, 3'd2, 32'(i * 4), 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 0);
      exec(1'b1, 3'd0, 32'h031, 32'h000000a5, 1'b1, 1'b0, 1'b0, 32'h0, 0);
      exec(1'b0, 3'd2, 32'h030, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 0);

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? $urandom
                                         : 32'($urandom_range(0, 1023));
         exec(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
              1'($urandom), 1'b0, 1'b0, 32'h0, 0);
      end

      idle_check();
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd0;
      req_addr   = 32'h020;
      req_wdata  = 32'h00000077;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_in_rd", mem_read, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_rst_read", mem_read, 0);
      chk("abort_rst_write", mem_write, 0);
      chk("abort_rst_ready", req_ready, 0);
      @(posedge clk);
      #1;
      chk("abort_outputs", {resp_valid, resp_err, resp_rdata, mem_read,
                            mem_write, mem_address, stall}, 0);
      chk("abort_wdata", mem_wdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid || mem_write) bad++;
      end
      chk("abort_no_resp", bad, 0);
      chk("abort_word8", mem[8], ref_mem[8]);

      exec(1'b0, 3'd2, 32'h020, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0);

      bad = 0;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== ref_mem[i]) bad++;
      chk("final_mem", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
